// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// ALU function codes and the datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   // ALU codes share the R-type funct numbering so funct can pass straight through.
   localparam logic [5:0] ALU_ADD  = 6'h20;
   localparam logic [5:0] ALU_SUB  = 6'h22;

   typedef enum logic [1:0] {
      SRCB_REG     = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pc_source_e;

   function automatic logic is_legal_op(input logic [5:0] op);
      logic legal;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: legal = 1'b1;
         default:                                       legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/stall_timer.sv
// 8-bit serial stall counter: cleared outside MEM, counts stalled cycles,
// flags when the count has reached the abort limit.
module stall_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic match_o
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      else if (enable_i)
         count_d = count_q + 8'd1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign match_o = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Five-state multicycle MIPS control FSM with serial-port stall handling
// and a bounded wait that aborts to FETCH on timeout.
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       addr_is_serial,
   input  logic       serial_valid_in,
   input  logic       serial_ready_in,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [5:0] alu_op,
   output logic       illegal_op,
   output logic       timeout,
   output logic [2:0] state_out
);

   state_e state_q, state_d;
   logic   stall_en;
   logic   stall_match;
   logic   hs_flag;

   stall_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_stall_timer (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (state_q != S_MEM),
      .enable_i (stall_en),
      .match_o  (stall_match)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state_q <= S_FETCH;
      else
         state_q <= state_d;
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      pc_source  = PCSRC_ALU;
      alu_op     = '0;
      illegal_op = 1'b0;
      timeout    = 1'b0;
      stall_en   = 1'b0;
      hs_flag    = (opcode == OP_LW) ? serial_valid_in : serial_ready_in;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = SRCB_FOUR;
            pc_source = PCSRC_ALU;
            state_d   = S_DECODE;
         end

         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH2;
            alu_op    = ALU_ADD;
            if (is_legal_op(opcode)) begin
               state_d = S_EXEC;
            end else begin
               illegal_op = 1'b1;
               state_d    = S_FETCH;
            end
         end

         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode)
               OP_RTYPE: begin
                  alu_src_a = 1'b1;
                  alu_src_b = SRCB_REG;
                  alu_op    = funct;
                  state_d   = S_WB;
               end
               OP_LW, OP_SW, OP_ADDI: begin
                  alu_src_a = 1'b1;
                  alu_src_b = SRCB_IMM;
                  alu_op    = ALU_ADD;
                  state_d   = (opcode == OP_ADDI) ? S_WB : S_MEM;
               end
               OP_BEQ: begin
                  alu_src_a = 1'b1;
                  alu_src_b = SRCB_REG;
                  alu_op    = ALU_SUB;
                  pc_source = PCSRC_ALUOUT;
                  pc_write  = alu_zero;
               end
               OP_J: begin
                  pc_source = PCSRC_JUMP;
                  pc_write  = 1'b1;
               end
               default: ;
            endcase
         end

         S_MEM: begin
            // A completing handshake takes priority over an expiring stall budget.
            if (!addr_is_serial || hs_flag) begin
               mem_read  = (opcode == OP_LW);
               mem_write = (opcode == OP_SW);
               state_d   = (opcode == OP_LW) ? S_WB : S_FETCH;
            end else if (stall_match) begin
               timeout = 1'b1;
               state_d = S_FETCH;
            end else begin
               mem_read  = (opcode == OP_LW);
               mem_write = (opcode == OP_SW);
               stall_en  = 1'b1;
            end
         end

         S_WB: begin
            state_d = S_FETCH;
            case (opcode)
               OP_RTYPE: begin
                  reg_write = 1'b1;
                  reg_dst   = 1'b1;
               end
               OP_ADDI: reg_write = 1'b1;
               OP_LW: begin
                  reg_write  = 1'b1;
                  mem_to_reg = 1'b1;
               end
               default: ;
            endcase
         end

         default: state_d = S_FETCH;
      endcase
   end

   assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: two controllers (default TIMEOUT and TIMEOUT=4) share one
// stimulus stream; outputs are compared against hand-computed constants.
module tb_multicycle_controller;
   import mips_ctrl_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       alu_zero = 1'b0;
   logic       addr_is_serial = 1'b0;
   logic       serial_valid_in = 1'b0;
   logic       serial_ready_in = 1'b0;

   logic       pw_a, ir_a, mr_a, mw_a, rw_a, rd_a, m2r_a, asa_a, ill_a, to_a;
   logic [1:0] srcb_a, pcs_a;
   logic [5:0] aop_a;
   logic [2:0] st_a;
   logic       pw_b, ir_b, mr_b, mw_b, rw_b, rd_b, m2r_b, asa_b, ill_b, to_b;
   logic [1:0] srcb_b, pcs_b;
   logic [5:0] aop_b;
   logic [2:0] st_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   multicycle_controller dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .addr_is_serial(addr_is_serial),
      .serial_valid_in(serial_valid_in), .serial_ready_in(serial_ready_in),
      .pc_write(pw_a), .ir_write(ir_a), .mem_read(mr_a), .mem_write(mw_a),
      .reg_write(rw_a), .reg_dst(rd_a), .mem_to_reg(m2r_a), .alu_src_a(asa_a),
      .alu_src_b(srcb_a), .pc_source(pcs_a), .alu_op(aop_a),
      .illegal_op(ill_a), .timeout(to_a), .state_out(st_a)
   );

   multicycle_controller #(.TIMEOUT(4)) dut_t4 (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .addr_is_serial(addr_is_serial),
      .serial_valid_in(serial_valid_in), .serial_ready_in(serial_ready_in),
      .pc_write(pw_b), .ir_write(ir_b), .mem_read(mr_b), .mem_write(mw_b),
      .reg_write(rw_b), .reg_dst(rd_b), .mem_to_reg(m2r_b), .alu_src_a(asa_b),
      .alu_src_b(srcb_b), .pc_source(pcs_b), .alu_op(aop_b),
      .illegal_op(ill_b), .timeout(to_b), .state_out(st_b)
   );

   // Flag bus: pc_write ir_write mem_read mem_write reg_write reg_dst mem_to_reg alu_src_a | alu_src_b | pc_source | illegal_op | timeout
   wire [13:0] bits_a = {pw_a, ir_a, mr_a, mw_a, rw_a, rd_a, m2r_a, asa_a, srcb_a, pcs_a, ill_a, to_a};
   wire [13:0] bits_b = {pw_b, ir_b, mr_b, mw_b, rw_b, rd_b, m2r_b, asa_b, srcb_b, pcs_b, ill_b, to_b};

   localparam logic [13:0] F_FETCH   = 14'b1110_0000_01_00_0_0;
   localparam logic [13:0] F_DECODE  = 14'b0000_0000_11_00_0_0;
   localparam logic [13:0] F_DEC_ILL = 14'b0000_0000_11_00_1_0;
   localparam logic [13:0] F_EXEC_R  = 14'b0000_0001_00_00_0_0;
   localparam logic [13:0] F_EXEC_M  = 14'b0000_0001_10_00_0_0;
   localparam logic [13:0] F_BEQ_T   = 14'b1000_0001_00_01_0_0;
   localparam logic [13:0] F_BEQ_N   = 14'b0000_0001_00_01_0_0;
   localparam logic [13:0] F_J       = 14'b1000_0000_00_10_0_0;
   localparam logic [13:0] F_MEM_LW  = 14'b0010_0000_00_00_0_0;
   localparam logic [13:0] F_MEM_SW  = 14'b0001_0000_00_00_0_0;
   localparam logic [13:0] F_TIMEOUT = 14'b0000_0000_00_00_0_1;
   localparam logic [13:0] F_WB_R    = 14'b0000_1100_00_00_0_0;
   localparam logic [13:0] F_WB_ADDI = 14'b0000_1000_00_00_0_0;
   localparam logic [13:0] F_WB_LW   = 14'b0000_1010_00_00_0_0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks the current cycle of one instance, then advances to 1ns past the next rising edge.
   task automatic cyc(input string tag, input bit sel, input logic [2:0] st,
                      input logic [13:0] bits, input logic [5:0] aop);
      #1;
      chk({tag, ".state"}, 16'(sel ? st_b : st_a), 16'(st));
      chk({tag, ".ctrl"}, 16'(sel ? bits_b : bits_a), 16'(bits));
      chk({tag, ".alu_op"}, 16'(sel ? aop_b : aop_a), 16'(aop));
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset state: FETCH outputs, nothing else.
      #3;
      chk("rst.state", 16'(st_a), 16'd0);
      chk("rst.ctrl", 16'(bits_a), 16'(F_FETCH));
      chk("rst.t4.ctrl", 16'(bits_b), 16'(F_FETCH));
      @(negedge clock);
      reset = 1'b1;

      // R-type add, then R-type or to see funct pass through.
      opcode = OP_RTYPE; funct = 6'h20;
      cyc("radd.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("radd.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("radd.exec", 0, 3'd2, F_EXEC_R, 6'h20);
      cyc("radd.wb", 0, 3'd4, F_WB_R, 6'h00);
      funct = 6'h25;
      cyc("ror.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("ror.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("ror.exec", 0, 3'd2, F_EXEC_R, 6'h25);
      cyc("ror.wb", 0, 3'd4, F_WB_R, 6'h00);

      // LW to RAM: five cycles.
      opcode = OP_LW; funct = 6'h00;
      cyc("lw.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("lw.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("lw.exec", 0, 3'd2, F_EXEC_M, 6'h20);
      cyc("lw.mem", 0, 3'd3, F_MEM_LW, 6'h00);
      cyc("lw.wb", 0, 3'd4, F_WB_LW, 6'h00);

      // ADDI: four cycles.
      opcode = OP_ADDI;
      cyc("addi.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("addi.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("addi.exec", 0, 3'd2, F_EXEC_M, 6'h20);
      cyc("addi.wb", 0, 3'd4, F_WB_ADDI, 6'h00);

      // BEQ taken then not taken: three cycles each.
      opcode = OP_BEQ; alu_zero = 1'b1;
      cyc("beq1.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("beq1.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("beq1.exec", 0, 3'd2, F_BEQ_T, 6'h22);
      alu_zero = 1'b0;
      cyc("beq0.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("beq0.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("beq0.exec", 0, 3'd2, F_BEQ_N, 6'h22);

      // Jump.
      opcode = OP_J;
      cyc("j.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("j.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("j.exec", 0, 3'd2, F_J, 6'h00);

      // Illegal opcode: pulse in DECODE, straight back to FETCH.
      opcode = 6'h3F;
      cyc("ill.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("ill.decode", 0, 3'd1, F_DEC_ILL, 6'h20);

      // SW to serial: ready low 10 MEM cycles, high on the 11th.
      opcode = OP_SW; addr_is_serial = 1'b1; serial_ready_in = 1'b0;
      cyc("sws.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("sws.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("sws.exec", 0, 3'd2, F_EXEC_M, 6'h20);
      for (int i = 0; i < 11; i++) begin
         serial_ready_in = (i == 10);
         cyc($sformatf("sws.mem%0d", i), 0, 3'd3, F_MEM_SW, 6'h00);
      end
      serial_ready_in = 1'b0;
      cyc("sws.after", 0, 3'd0, F_FETCH, 6'h00);

      // Resynchronise both instances.
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      // LW from serial, valid held low, TIMEOUT=4 instance.
      opcode = OP_LW; serial_valid_in = 1'b0;
      cyc("to.fetch", 1, 3'd0, F_FETCH, 6'h00);
      cyc("to.decode", 1, 3'd1, F_DECODE, 6'h20);
      cyc("to.exec", 1, 3'd2, F_EXEC_M, 6'h20);
      for (int i = 0; i < 4; i++)
         cyc($sformatf("to.stall%0d", i), 1, 3'd3, F_MEM_LW, 6'h00);
      cyc("to.pulse", 1, 3'd3, F_TIMEOUT, 6'h00);
      cyc("to.after", 1, 3'd0, F_FETCH, 6'h00);

      // Handshake arriving on the timeout cycle wins.
      cyc("hw.decode", 1, 3'd1, F_DECODE, 6'h20);
      cyc("hw.exec", 1, 3'd2, F_EXEC_M, 6'h20);
      for (int i = 0; i < 4; i++)
         cyc($sformatf("hw.stall%0d", i), 1, 3'd3, F_MEM_LW, 6'h00);
      serial_valid_in = 1'b1;
      cyc("hw.mem", 1, 3'd3, F_MEM_LW, 6'h00);
      serial_valid_in = 1'b0;
      cyc("hw.wb", 1, 3'd4, F_WB_LW, 6'h00);

      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      // Reset in the middle of an SW serial stall.
      opcode = OP_SW; serial_ready_in = 1'b0;
      cyc("rs.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("rs.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("rs.exec", 0, 3'd2, F_EXEC_M, 6'h20);
      cyc("rs.mem0", 0, 3'd3, F_MEM_SW, 6'h00);
      cyc("rs.mem1", 0, 3'd3, F_MEM_SW, 6'h00);
      #2;
      reset = 1'b0;
      #1;
      chk("rs.async.state", 16'(st_a), 16'd0);
      chk("rs.async.ctrl", 16'(bits_a), 16'(F_FETCH));
      @(posedge clock);
      #1;
      chk("rs.held.state", 16'(st_a), 16'd0);

      // First fetch after release happens at the first rising edge.
      opcode = OP_J; addr_is_serial = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      cyc("rel.fetch", 0, 3'd0, F_FETCH, 6'h00);
      cyc("rel.decode", 0, 3'd1, F_DECODE, 6'h20);
      cyc("rel.exec", 0, 3'd2, F_J, 6'h00);
      cyc("rel.after", 0, 3'd0, F_FETCH, 6'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
